// File: rtl/stream_id_router.sv
// Steers a merged stream back out to per-id outputs, one register slot per
// output; packets with an unknown id are swallowed and counted.
module stream_id_router #(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_QOS__WIDTH = 2,
  parameter int STREAM_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_in,
  input  logic [T_QOS__WIDTH-1:0] s_qos_in,
  input  logic [T_ID___WIDTH-1:0] s_id_in,
  input  logic                    s_last_in,
  input  logic                    s_valid_in,
  output logic                    s_ready_out,
  output logic [T_DATA_WIDTH-1:0] m_data_out [STREAM_COUNT],
  output logic [T_QOS__WIDTH-1:0] m_qos_out [STREAM_COUNT],
  output logic [STREAM_COUNT-1:0] m_last_out,
  output logic [STREAM_COUNT-1:0] m_valid_out,
  input  logic [STREAM_COUNT-1:0] m_ready_in,
  output logic                    pkt_active_out,
  output logic [15:0]             drop_cnt_out
);

  localparam logic [T_ID___WIDTH:0] N_EXT =
    (T_ID___WIDTH+1)'(STREAM_COUNT);

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

  state_t                  state_q, state_d;
  logic [T_ID___WIDTH-1:0] dest_q, dest_d;
  logic [T_ID___WIDTH-1:0] eff_dest;
  logic                    in_range;
  logic                    drop_beat;
  logic                    accept;
  logic                    drop_done;
  logic [STREAM_COUNT-1:0] load;

  assign eff_dest = (state_q == IDLE) ? s_id_in : dest_q;
  assign in_range = {1'b0, eff_dest} < N_EXT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dest_d = s_id_in;
          if (!s_last_in)
            state_d = in_range ? ROUTE : DROP;
        end
      end
      ROUTE, DROP: begin
        if (accept && s_last_in)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready only looks at the slot this beat is headed for.
  always_comb begin
    drop_beat = (state_q == DROP) ||
                (state_q == IDLE && !in_range);
    if (drop_beat)
      s_ready_out = 1'b1;
    else
      s_ready_out = !m_valid_out[eff_dest] ||
                    m_ready_in[eff_dest];
    accept    = s_valid_in && s_ready_out;
    drop_done = accept && drop_beat && s_last_in;
    load      = '0;
    for (int i = 0; i < STREAM_COUNT; i++)
      load[i] = accept && !drop_beat &&
                (eff_dest == T_ID___WIDTH'(i));
  end

  assign pkt_active_out = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_out <= '0;
      m_last_out  <= '0;
      for (int i = 0; i < STREAM_COUNT; i++) begin
        m_data_out[i] <= '0;
        m_qos_out[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < STREAM_COUNT; i++) begin
        if (load[i]) begin
          m_valid_out[i] <= 1'b1;
          m_data_out[i]  <= s_data_in;
          m_qos_out[i]   <= s_qos_in;
          m_last_out[i]  <= s_last_in;
        end else if (m_ready_in[i]) begin
          m_valid_out[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt_out <= '0;
    else if (drop_done && drop_cnt_out != 16'hFFFF)
      drop_cnt_out <= drop_cnt_out + 16'd1;
  end

endmodule
